axi_err_slave: RTL and testbench

AXI_ERR_SLAVE -- requirements
Module: axi_err_slave

---
 rtl/axi_err_slave_if.sv | 36 +++
 rtl/axi_err_slave.sv | 149 ++++++++++++++
 tb/tb_axi_err_slave.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_err_slave_if.sv
// AXI4 channel bundle for the default (error) slave: AW, W, B, AR and R handshakes.
interface axi_err_slave_if #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]   AWID;
  logic              AWVALID;
  logic              AWREADY;
  logic              WVALID;
  logic              WLAST;
  logic              WREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ID_W-1:0]   ARID;
  logic [7:0]        ARLEN;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  AWID, AWVALID, WVALID, WLAST, BREADY, ARID, ARLEN, ARVALID, RREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output AWID, AWVALID, WVALID, WLAST, BREADY, ARID, ARLEN, ARVALID, RREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_err_slave.sv
// AXI4 default slave for the unmapped region: accepts every burst and answers
// with DECERR. Write and read sides are independent FSMs; every output comes
// straight from a flop so no VALID->READY combinational path exists.
module axi_err_slave #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  axi_err_slave_if.slave  bus,
  output logic [15:0]     err_cnt
);

  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Saturating add for the error counter; never wraps past 16'hFFFF.
  function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  w_state_t        w_state, w_state_n;
  logic            awready_q, awready_n;
  logic            wready_q, wready_n;
  logic            bvalid_q, bvalid_n;
  logic [ID_W-1:0] bid_q, bid_n;
  logic [1:0]      bresp_q, bresp_n;

  r_state_t        r_state, r_state_n;
  logic            arready_q, arready_n;
  logic            rvalid_q, rvalid_n;
  logic            rlast_q, rlast_n;
  logic [ID_W-1:0] rid_q, rid_n;
  logic [1:0]      rresp_q, rresp_n;
  logic [7:0]      cnt_q, cnt_n;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = bus.AWVALID & awready_q;
  assign w_hs  = bus.WVALID  & wready_q;
  assign b_hs  = bvalid_q    & bus.BREADY;
  assign ar_hs = bus.ARVALID & arready_q;
  assign r_hs  = rvalid_q    & bus.RREADY;

  // Write side: next state, then registered outputs decoded from the next state.
  always_comb begin
    w_state_n = w_state;
    bid_n     = bid_q;
    case (w_state)
      W_IDLE: if (aw_hs) begin
        w_state_n = W_DATA;
        bid_n     = bus.AWID;
      end
      W_DATA:  if (w_hs && bus.WLAST) w_state_n = W_RESP;
      W_RESP:  if (b_hs) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
    awready_n = (w_state_n == W_IDLE);
    wready_n  = (w_state_n == W_DATA);
    bvalid_n  = (w_state_n == W_RESP);
    bresp_n   = bvalid_n ? DECERR : 2'b00;
  end

  // Write side state and output registers; reset abandons any open burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
    end else begin
      w_state   <= w_state_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bvalid_q  <= bvalid_n;
      bid_q     <= bid_n;
      bresp_q   <= bresp_n;
    end
  end

  // Read side: beat counter walks ARLEN down to zero; RLAST flags the zero beat.
  always_comb begin
    r_state_n = r_state;
    rid_n     = rid_q;
    cnt_n     = cnt_q;
    case (r_state)
      R_IDLE: if (ar_hs) begin
        r_state_n = R_DATA;
        rid_n     = bus.ARID;
        cnt_n     = bus.ARLEN;
      end
      R_DATA: if (r_hs) begin
        if (cnt_q == 8'd0) r_state_n = R_IDLE;
        else               cnt_n     = cnt_q - 8'd1;
      end
      default: r_state_n = R_IDLE;
    endcase
    arready_n = (r_state_n == R_IDLE);
    rvalid_n  = (r_state_n == R_DATA);
    rlast_n   = rvalid_n && (cnt_n == 8'd0);
    rresp_n   = rvalid_n ? DECERR : 2'b00;
  end

  // Read side state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= 2'b00;
      cnt_q     <= 8'd0;
    end else begin
      r_state   <= r_state_n;
      arready_q <= arready_n;
      rvalid_q  <= rvalid_n;
      rlast_q   <= rlast_n;
      rid_q     <= rid_n;
      rresp_q   <= rresp_n;
      cnt_q     <= cnt_n;
    end
  end

  // Count accepted unmapped transactions; AW and AR in one cycle add two.
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= 16'd0;
    else     err_cnt <= sat_add(err_cnt, {1'b0, aw_hs} + {1'b0, ar_hs});
  end

  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BID     = bid_q;
  assign bus.BRESP   = bresp_q;
  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RLAST   = rlast_q;
  assign bus.RID     = rid_q;
  assign bus.RRESP   = rresp_q;
  assign bus.RDATA   = {DATA_W{1'b0}};

endmodule

// File: tb/tb_axi_err_slave.sv
// Bench for axi_err_slave: transaction-queue reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_axi_err_slave;
  localparam int ID_W   = 4;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] err_cnt;
  bit          chk_on = 1'b0;
  int          checks = 0;
  int          errors = 0;

  axi_err_slave_if #(.ID_W(ID_W), .DATA_W(DATA_W)) bus ();

  axi_err_slave #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding transactions held as queues.
  typedef struct packed {logic [ID_W-1:0] id; logic last;} rbeat_t;
  logic [ID_W-1:0] aw_q[$];   // write address accepted, data still arriving
  logic [ID_W-1:0] b_q[$];    // responses owed
  rbeat_t          r_q[$];    // read beats owed
  int              m_err = 0;
  bit              m_rst = 1'b1;
  bit              m_aw_hs, m_w_hs, m_b_hs, m_ar_hs, m_r_hs;

  function automatic bit e_awready(); return !m_rst && aw_q.size() == 0 && b_q.size() == 0; endfunction
  function automatic bit e_wready();  return aw_q.size() != 0; endfunction
  function automatic bit e_bvalid();  return b_q.size() != 0; endfunction
  function automatic bit e_arready(); return !m_rst && r_q.size() == 0; endfunction
  function automatic bit e_rvalid();  return r_q.size() != 0; endfunction

  always @(posedge clk) begin
    if (rst) begin
      aw_q.delete(); b_q.delete(); r_q.delete();
      m_err = 0;
      m_rst = 1'b1;
    end else begin
      m_aw_hs = bus.AWVALID && e_awready();
      m_w_hs  = bus.WVALID && e_wready();
      m_b_hs  = e_bvalid() && bus.BREADY;
      m_ar_hs = bus.ARVALID && e_arready();
      m_r_hs  = e_rvalid() && bus.RREADY;
      if (m_w_hs && bus.WLAST) b_q.push_back(aw_q.pop_front());
      if (m_b_hs) void'(b_q.pop_front());
      if (m_aw_hs) aw_q.push_back(bus.AWID);
      if (m_r_hs) void'(r_q.pop_front());
      if (m_ar_hs)
        for (int i = 0; i <= int'(bus.ARLEN); i++)
          r_q.push_back('{id: bus.ARID, last: (i == int'(bus.ARLEN))});
      m_err = m_err + int'(m_aw_hs) + int'(m_ar_hs);
      if (m_err > 65535) m_err = 65535;
      m_rst = 1'b0;
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      if (m_rst) begin
        chk("rst_awready", bus.AWREADY, 0); chk("rst_wready", bus.WREADY, 0);
        chk("rst_bvalid", bus.BVALID, 0);   chk("rst_arready", bus.ARREADY, 0);
        chk("rst_rvalid", bus.RVALID, 0);   chk("rst_rlast", bus.RLAST, 0);
        chk("rst_bid", bus.BID, 0);         chk("rst_rid", bus.RID, 0);
        chk("rst_rdata", bus.RDATA, 0);     chk("rst_bresp", bus.BRESP, 0);
        chk("rst_rresp", bus.RRESP, 0);     chk("rst_err_cnt", err_cnt, 0);
      end else begin
        chk("awready", bus.AWREADY, e_awready());
        chk("wready", bus.WREADY, e_wready());
        chk("bvalid", bus.BVALID, e_bvalid());
        chk("arready", bus.ARREADY, e_arready());
        chk("rvalid", bus.RVALID, e_rvalid());
        chk("err_cnt", err_cnt, m_err);
        if (e_bvalid()) begin
          chk("bid", bus.BID, b_q[0]);
          chk("bresp", bus.BRESP, 2'b11);
        end
        if (e_rvalid()) begin
          chk("rid", bus.RID, r_q[0].id);
          chk("rlast", bus.RLAST, r_q[0].last);
          chk("rdata", bus.RDATA, 0);
          chk("rresp", bus.RRESP, 2'b11);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.AWID = '0; bus.AWVALID = 0; bus.WVALID = 0; bus.WLAST = 0; bus.BREADY = 0;
    bus.ARID = '0; bus.ARLEN = '0; bus.ARVALID = 0; bus.RREADY = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int cnt, lasts;
    rst = 1'b1;
    idle_inputs();
    tick();
    chk_on = 1'b1;
    tick();
    chk("lit_reset_awready", bus.AWREADY, 0);
    chk("lit_reset_err", err_cnt, 0);
    rst = 1'b0;
    tick();
    chk("lit_post_rst_awready", bus.AWREADY, 1);
    chk("lit_post_rst_arready", bus.ARREADY, 1);

    // Single write: ID 5, four beats, response one cycle after WLAST beat.
    bus.BREADY = 1; bus.AWID = 4'd5; bus.AWVALID = 1;
    tick();
    bus.AWVALID = 0; bus.WVALID = 1;
    for (int b = 1; b <= 4; b++) begin
      bus.WLAST = (b == 4);
      chk("lit_w_bvalid_before", bus.BVALID, 0);
      tick();
    end
    bus.WVALID = 0; bus.WLAST = 0;
    chk("lit_w_bvalid", bus.BVALID, 1);
    chk("lit_w_bid", bus.BID, 5);
    chk("lit_w_bresp", bus.BRESP, 2'b11);
    tick();
    chk("lit_w_err", err_cnt, 1);
    chk("lit_w_awready_back", bus.AWREADY, 1);

    // Read of four beats with RREADY toggling.
    bus.ARID = 4'd3; bus.ARLEN = 8'd3; bus.ARVALID = 1;
    tick();
    bus.ARVALID = 0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      bus.RREADY = c[0];
      #1;
      if (bus.RVALID && bus.RREADY) begin
        cnt++;
        chk("lit_r_last", bus.RLAST, (cnt == 4));
        chk("lit_r_id", bus.RID, 3);
      end
      tick();
    end
    bus.RREADY = 0;
    chk("lit_r_beats", cnt, 4);
    chk("lit_r_err", err_cnt, 2);

    // AW and AR accepted in the same cycle.
    bus.AWID = 4'd7; bus.AWVALID = 1; bus.ARID = 4'd12; bus.ARLEN = 8'd0; bus.ARVALID = 1;
    tick();
    bus.AWVALID = 0; bus.ARVALID = 0;
    chk("lit_dual_err", err_cnt, 4);
    chk("lit_dual_wready", bus.WREADY, 1);
    chk("lit_dual_rvalid", bus.RVALID, 1);
    chk("lit_dual_rlast", bus.RLAST, 1);
    bus.WVALID = 1; bus.WLAST = 1; bus.RREADY = 1; bus.BREADY = 1;
    tick();
    bus.WVALID = 0; bus.WLAST = 0; bus.RREADY = 0;
    tick();

    // Response back-pressure for ten cycles while a new AW waits.
    bus.BREADY = 0; bus.AWID = 4'd9; bus.AWVALID = 1;
    tick();
    bus.AWID = 4'd10; bus.WVALID = 1; bus.WLAST = 1;
    tick();
    bus.WVALID = 0; bus.WLAST = 0;
    for (int c = 0; c < 10; c++) begin
      chk("lit_bp_bvalid", bus.BVALID, 1);
      chk("lit_bp_bid", bus.BID, 9);
      chk("lit_bp_awready", bus.AWREADY, 0);
      tick();
    end
    bus.BREADY = 1;
    tick();
    chk("lit_bp_awready_after", bus.AWREADY, 1);
    chk("lit_bp_bvalid_after", bus.BVALID, 0);
    tick();
    bus.AWVALID = 0; bus.WVALID = 1; bus.WLAST = 1;
    tick();
    bus.WVALID = 0; bus.WLAST = 0;
    chk("lit_bp_bid2", bus.BID, 10);
    tick();

    // 256-beat read.
    bus.ARID = 4'd6; bus.ARLEN = 8'd255; bus.ARVALID = 1; bus.RREADY = 1;
    tick();
    bus.ARVALID = 0;
    cnt = 0; lasts = 0;
    for (int c = 0; c < 300; c++) begin
      if (bus.RVALID) begin
        cnt++;
        if (bus.RLAST) begin
          lasts++;
          chk("lit_r256_last_pos", cnt, 256);
        end
      end
      tick();
    end
    chk("lit_r256_beats", cnt, 256);
    chk("lit_r256_lasts", lasts, 1);

    // Reset during beat 2 of an eight-beat read.
    bus.ARID = 4'd2; bus.ARLEN = 8'd7; bus.ARVALID = 1; bus.RREADY = 1;
    tick();
    bus.ARVALID = 0;
    tick();
    rst = 1;
    tick();
    chk("lit_midrst_rvalid", bus.RVALID, 0);
    chk("lit_midrst_err", err_cnt, 0);
    rst = 0;
    bus.RREADY = 0;
    tick();
    chk("lit_midrst_arready", bus.ARREADY, 1);
    chk("lit_midrst_awready", bus.AWREADY, 1);

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 1500; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      bus.AWID     = ID_W'($urandom);
      bus.AWVALID  = $urandom_range(0, 1);
      bus.WVALID   = $urandom_range(0, 1);
      bus.WLAST    = ($urandom_range(0, 2) == 0);
      bus.BREADY   = $urandom_range(0, 1);
      bus.ARID     = ID_W'($urandom);
      bus.ARLEN    = 8'($urandom_range(0, 5));
      bus.ARVALID  = $urandom_range(0, 1);
      bus.RREADY   = $urandom_range(0, 1);
      tick();
    end
    rst = 0;

    // Saturation: drive back-to-back reads and writes up to 16'hFFFF.
    do_reset();
    bus.ARVALID = 1; bus.ARLEN = 8'd0; bus.ARID = 4'd1; bus.RREADY = 1;
    bus.AWVALID = 1; bus.AWID = 4'd2; bus.WVALID = 1; bus.WLAST = 1; bus.BREADY = 1;
    cnt = 0;
    while (err_cnt !== 16'hFFFF && cnt < 90000) begin
      tick();
      cnt++;
    end
    chk("lit_sat_reached", err_cnt, 16'hFFFF);
    bus.AWVALID = 0; bus.WVALID = 0; bus.WLAST = 0;
    repeat (8) tick();
    chk("lit_sat_hold", err_cnt, 16'hFFFF);
    bus.ARVALID = 0; bus.RREADY = 1;
    repeat (3) tick();
    chk("lit_sat_final", err_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
